// File: rtl/bcd_display_driver_pkg.sv
// Shared definitions for the BCD display path: digit width, segment patterns and scan states.
// Segment vectors are ordered a..g with bit 0 = segment a.
package bcd_display_driver_pkg;

  localparam int unsigned DigitW = 4;
  localparam int unsigned SegW   = 7;

  typedef logic [DigitW-1:0] digit_t;
  typedef logic [0:SegW-1]   seg_t;

  localparam seg_t SegDig0 = 7'b1111110;
  localparam seg_t SegDig1 = 7'b0110000;
  localparam seg_t SegDig2 = 7'b1101101;
  localparam seg_t SegDig3 = 7'b1111001;
  localparam seg_t SegDig4 = 7'b0110011;
  localparam seg_t SegDig5 = 7'b1011011;
  localparam seg_t SegDig6 = 7'b1011111;
  localparam seg_t SegDig7 = 7'b1110000;
  localparam seg_t SegDig8 = 7'b1111111;
  localparam seg_t SegDig9 = 7'b1111011;
  localparam seg_t SegErr  = 7'b1001111;
  localparam seg_t SegOff  = 7'b0000000;

  // Scan state encoding
  localparam int unsigned StateW = 3;
  localparam logic [StateW-1:0] StBlank = 3'd0;
  localparam logic [StateW-1:0] StTens  = 3'd1;
  localparam logic [StateW-1:0] StGapT  = 3'd2;
  localparam logic [StateW-1:0] StUnits = 3'd3;
  localparam logic [StateW-1:0] StGapU  = 3'd4;

  function automatic logic is_bcd(input digit_t d);
    return d <= digit_t'(9);
  endfunction

endpackage

// File: rtl/bcd_display_driver_if.sv
// Capture bus (product + strobe) and the multiplexed display outputs of the BCD display driver.
// The producer/observer side uses master; the driver itself uses slave.
interface bcd_display_driver_if;
  import bcd_display_driver_pkg::*;

  logic [0:7] bcd_in;
  logic       load;
  seg_t       seg;
  logic [0:1] an;
  logic       err;

  modport master (
    output bcd_in,
    output load,
    input  seg,
    input  an,
    input  err
  );

  modport slave (
    input  bcd_in,
    input  load,
    output seg,
    output an,
    output err
  );

endinterface

// File: rtl/bcd_display_driver_bcd_to_seven_seg.sv
// Combinational 4-bit digit to seven-segment decoder; values 10..15 render as "E".
module bcd_to_seven_seg
  import bcd_display_driver_pkg::*;
(
  input  digit_t digit_i,
  output seg_t   seg_o
);

  always_comb begin
    seg_o = SegErr;
    case (digit_i)
      4'd0:    seg_o = SegDig0;
      4'd1:    seg_o = SegDig1;
      4'd2:    seg_o = SegDig2;
      4'd3:    seg_o = SegDig3;
      4'd4:    seg_o = SegDig4;
      4'd5:    seg_o = SegDig5;
      4'd6:    seg_o = SegDig6;
      4'd7:    seg_o = SegDig7;
      4'd8:    seg_o = SegDig8;
      4'd9:    seg_o = SegDig9;
      default: seg_o = SegErr;
    endcase
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Holds a two-digit BCD product and scans it onto two multiplexed seven-segment digits,
// with a blanking gap between slots and an error flag for non-BCD digits.
module bcd_display_driver
  import bcd_display_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter int unsigned GUARD_CYC     = 2,
  parameter bit          BLANK_LEADING = 1'b1,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  bcd_display_driver_if.slave bus
);

  localparam int unsigned MaxCyc = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] RefreshLast = CntW'(REFRESH_DIV - 1);
  // Only compared in gap states, which do not exist when GUARD_CYC is 0
  localparam logic [CntW-1:0] GuardLast   = CntW'((GUARD_CYC == 0) ? 0 : GUARD_CYC - 1);
  localparam bit              HasGap      = (GUARD_CYC != 0);

  localparam seg_t       SegInv = {SegW{ACTIVE_LOW}};
  localparam logic [0:1] AnInv  = {2{ACTIVE_LOW}};

  logic [0:7]        hold_q;
  logic              err_q;
  logic [StateW-1:0] state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  digit_t     tens, units, digit_sel;
  seg_t       seg_dec, seg_d, seg_q;
  logic [0:1] an_d, an_q;
  logic       load_err;

  assign tens  = hold_q[0:3];
  assign units = hold_q[4:7];

  assign load_err = !is_bcd(bus.bcd_in[0:3]) || !is_bcd(bus.bcd_in[4:7]);

  // Scan sequencer: counter restarts on every state change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      StBlank: begin
        cnt_d = '0;
        if (bus.load) begin
          state_d = StTens;
        end
      end
      StTens: begin
        if (cnt_q == RefreshLast) begin
          state_d = HasGap ? StGapT : StUnits;
          cnt_d   = '0;
        end
      end
      StGapT: begin
        if (cnt_q == GuardLast) begin
          state_d = StUnits;
          cnt_d   = '0;
        end
      end
      StUnits: begin
        if (cnt_q == RefreshLast) begin
          state_d = HasGap ? StGapU : StTens;
          cnt_d   = '0;
        end
      end
      StGapU: begin
        if (cnt_q == GuardLast) begin
          state_d = StTens;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StBlank;
        cnt_d   = '0;
      end
    endcase
  end

  assign digit_sel = (state_q == StTens) ? tens : units;

  bcd_to_seven_seg u_dec (
    .digit_i (digit_sel),
    .seg_o   (seg_dec)
  );

  // Logical (active-high) display image for the current state
  always_comb begin
    seg_d = SegOff;
    an_d  = 2'b00;
    case (state_q)
      StTens: begin
        if (!(BLANK_LEADING && (tens == '0))) begin
          an_d  = 2'b10;
          seg_d = seg_dec;
        end
      end
      StUnits: begin
        an_d  = 2'b01;
        seg_d = seg_dec;
      end
      default: begin
        seg_d = SegOff;
        an_d  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBlank;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      err_q  <= 1'b0;
    end else if (bus.load) begin
      hold_q <= bus.bcd_in;
      err_q  <= load_err;
    end
  end

  // Polarity applied before the register so the pins come straight from flops
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SegOff ^ SegInv;
      an_q  <= 2'b00 ^ AnInv;
    end else begin
      seg_q <= seg_d ^ SegInv;
      an_q  <= an_d ^ AnInv;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Bench for bcd_display_driver: three parameterisations driven in lockstep and checked every
// cycle against a slot-position model of the scan.
module tb_bcd_display_driver;

  localparam int NDut = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] bcd_in;

  always #5 clk = ~clk;

  bcd_display_driver_if if_a ();
  bcd_display_driver_if if_b ();
  bcd_display_driver_if if_c ();

  assign if_a.bcd_in = bcd_in;
  assign if_a.load   = load;
  assign if_b.bcd_in = bcd_in;
  assign if_b.load   = load;
  assign if_c.bcd_in = bcd_in;
  assign if_c.load   = load;

  bcd_display_driver #(
    .REFRESH_DIV   (4),
    .GUARD_CYC     (1),
    .BLANK_LEADING (1'b1),
    .ACTIVE_LOW    (1'b0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  bcd_display_driver #(
    .REFRESH_DIV   (4),
    .GUARD_CYC     (1),
    .BLANK_LEADING (1'b0),
    .ACTIVE_LOW    (1'b0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  bcd_display_driver #(
    .REFRESH_DIV   (3),
    .GUARD_CYC     (0),
    .BLANK_LEADING (1'b1),
    .ACTIVE_LOW    (1'b1)
  ) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (if_c)
  );

  int unsigned p_r  [NDut] = '{4, 4, 3};
  int unsigned p_g  [NDut] = '{1, 1, 0};
  bit          p_bl [NDut] = '{1'b1, 1'b0, 1'b1};
  bit          p_al [NDut] = '{1'b0, 1'b0, 1'b1};

  // Model: scanning flag, position within the scan period, held value, error flag
  bit          m_run  [NDut];
  int unsigned m_pos  [NDut];
  logic [7:0]  m_hold [NDut];
  bit          m_err  [NDut];

  int errors = 0;
  int checks = 0;

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b1001111;
    endcase
  endfunction

  function automatic logic [9:0] obs(input int k);
    case (k)
      0:       return {if_a.err, if_a.an, if_a.seg};
      1:       return {if_b.err, if_b.an, if_b.seg};
      default: return {if_c.err, if_c.an, if_c.seg};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic expect_out(input int k, output logic [6:0] es, output logic [1:0] ea);
    int unsigned p;
    es = 7'b0;
    ea = 2'b00;
    if (m_run[k]) begin
      p = m_pos[k];
      if (p < p_r[k]) begin
        if (!(p_bl[k] && m_hold[k][7:4] == 4'd0)) begin
          ea = 2'b10;
          es = pat(m_hold[k][7:4]);
        end
      end else if (p >= p_r[k] + p_g[k] && p < 2 * p_r[k] + p_g[k]) begin
        ea = 2'b01;
        es = pat(m_hold[k][3:0]);
      end
    end
  endtask

  task automatic tick(input logic r, input logic l, input logic [7:0] d);
    logic [6:0] es;
    logic [1:0] ea;
    logic [9:0] o;
    logic [1:0] an_log;
    rst    = r;
    load   = l;
    bcd_in = d;
    @(posedge clk);
    #1;
    for (int k = 0; k < NDut; k++) begin
      o = obs(k);
      if (r) begin
        es = 7'b0;
        ea = 2'b00;
      end else begin
        expect_out(k, es, ea);
      end
      if (r) begin
        m_run[k]  = 1'b0;
        m_pos[k]  = 0;
        m_hold[k] = 8'h00;
        m_err[k]  = 1'b0;
      end else begin
        if (m_run[k]) m_pos[k] = (m_pos[k] + 1) % (2 * (p_r[k] + p_g[k]));
        if (l) begin
          m_hold[k] = d;
          m_err[k]  = (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
          if (!m_run[k]) begin
            m_run[k] = 1'b1;
            m_pos[k] = 0;
          end
        end
      end
      if (p_al[k]) begin
        es = ~es;
        ea = ~ea;
      end
      an_log = o[8:7] ^ {2{p_al[k]}};
      chk($sformatf("dut%0d seg", k), {1'b0, o[6:0]}, {1'b0, es});
      chk($sformatf("dut%0d an", k), {6'b0, o[8:7]}, {6'b0, ea});
      chk($sformatf("dut%0d err", k), {7'b0, o[9]}, {7'b0, m_err[k]});
      chk($sformatf("dut%0d an_excl", k), {7'b0, &an_log}, 8'h00);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    bit reached;
    for (int k = 0; k < NDut; k++) begin
      m_run[k]  = 1'b0;
      m_pos[k]  = 0;
      m_hold[k] = 8'h00;
      m_err[k]  = 1'b0;
    end
    rst    = 1'b1;
    load   = 1'b0;
    bcd_in = 8'h00;

    // Reset, then stay blank with no load
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    idle(30);

    // Plain two-digit value
    tick(1'b0, 1'b1, 8'h56);
    idle(25);

    // Leading zero
    tick(1'b0, 1'b1, 8'h07);
    idle(22);

    // Invalid tens digit
    tick(1'b0, 1'b1, 8'hA3);
    idle(22);

    // Load in the middle of a units slot of dut_a
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (m_pos[0] == p_r[0] + p_g[0] + 1) reached = 1'b1;
      else tick(1'b0, 1'b0, 8'h00);
    end
    chk("wait_units", {7'b0, reached}, 8'h01);
    tick(1'b0, 1'b1, 8'h81);
    idle(20);

    // Reset together with load mid-tens: load must be ignored
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (m_pos[0] == 1) reached = 1'b1;
      else tick(1'b0, 1'b0, 8'h00);
    end
    chk("wait_tens", {7'b0, reached}, 8'h01);
    tick(1'b1, 1'b1, 8'h99);
    idle(12);

    // Random loads, values (including non-BCD) and occasional resets
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0), 8'($urandom));
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_display_driver.md
Name: bcd_display_driver

Overview:
- Downstream consumer of the two-digit BCD product produced by the single-digit BCD multiplier.
- Captures the 8-bit BCD product on a load strobe and holds it.
- Drives two multiplexed common-anode/cathode seven-segment digits with a time-sliced scan and an anti-ghosting gap.
- Flags captured digits that are not valid BCD, and displays "E" in their place.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays enabled per scan slot; must be >= 2.
- GUARD_CYC, 2: cycles with both digits disabled between slots (anti-ghosting); 0 removes the gap states.
- BLANK_LEADING, 1: when 1, a tens digit of 0 is not lit.
- ACTIVE_LOW, 1: when 1, seg and an are inverted at the output (off = all ones).

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- bcd_in  input  [0:7]  product from the multiplier; bit 0 is MSB; [0:3] = tens digit, [4:7] = units digit
- load  input  1  capture strobe, sampled each clk edge
- seg  output  [0:6]  segments a..g; bit 0 = a; registered
- an  output  [0:1]  digit enables; an[0] = tens, an[1] = units; registered
- err  output  1  high while the held value has a digit > 9; registered

Behaviour:
- One clock domain; reset is synchronous and active-high (rst sampled on the rising edge of clk); rst has priority over load.
- Reset values (logical, before ACTIVE_LOW inversion):
  - hold register = 0x00
  - state = BLANK
  - slot counter = 0
  - seg = 0000000, an = 00, err = 0
  - After ACTIVE_LOW=1 inversion, seg = 1111111 and an = 11.
- Capture: at an edge with load=1 and rst=0, hold <= bcd_in and err <= (tens > 9) | (units > 9). The held value persists until the next load.
- States:
  - BLANK
  - TENS
  - GAP_T
  - UNITS
  - GAP_U
- Transitions:
  - BLANK: entered only by reset. Outputs are off. A load moves the FSM to TENS with counter = 0.
  - TENS: lasts REFRESH_DIV cycles, then goes to GAP_T.
  - GAP_T: lasts GUARD_CYC cycles, then goes to UNITS.
  - UNITS: lasts REFRESH_DIV cycles, then goes to GAP_U.
  - GAP_U: lasts GUARD_CYC cycles, then goes to TENS.
  - If GUARD_CYC = 0, TENS goes directly to UNITS and UNITS directly to TENS.
- Counter: counts 0..N-1 within each state and is cleared on every state change. Width is clog2 of max(REFRESH_DIV, GUARD_CYC).
- A load while scanning updates hold only. The FSM and counter are not disturbed, and the new value appears in the current or next digit slot.
- Output timing: seg and an are registered. They reflect the state and hold value one cycle after those change, so each lit window is exactly REFRESH_DIV cycles, delayed by 1 cycle.
- Lit digit, TENS slot: an = 10, seg = pattern(tens).
  - If BLANK_LEADING=1 and tens = 0, an = 00 and seg = 0000000.
- Lit digit, UNITS slot: an = 01, seg = pattern(units). The units digit is always lit.
- Gap states: an = 00, seg = 0000000.
- Decode patterns (a..g):
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
  - 8 = 1111111
  - 9 = 1111011
  - any value 10..15 = "E" = 1001111
- Reset mid-slot: at the next edge the FSM is in BLANK and outputs are off. The display stays blank until a load.
- At no edge are both an bits asserted.

Decomposition:
- Shared package holds:
  - seven-segment pattern constants for 0-9 and E
  - the state enumeration
  - the BCD digit width constant (4)
- Natural sub-module: bcd_to_seven_seg. It is a combinational 4-bit to 7-bit decoder including the E pattern, and is reused by later display blocks.
- The FSM, counter, hold register and output registers live in the top block.

Test Plan:
All scenarios use REFRESH_DIV=4, GUARD_CYC=1, ACTIVE_LOW=0, BLANK_LEADING=1 unless stated.
- Reset, no load for 30 cycles -> seg=0000000, an=00, err=0 throughout.
- Load 0x56 -> repeating pattern:
  - an=10, seg=1011011 for 4 cycles
  - an=00 for 1 cycle
  - an=01, seg=1011111 for 4 cycles
  - an=00 for 1 cycle
  - period 10 cycles; err=0.
- Load 0x07 -> tens slot an=00, seg=0000000; units slot an=01, seg=1110000.
- Repeat 0x07 with BLANK_LEADING=0 -> tens slot an=10, seg=1111110.
- Load 0xA3 -> err=1; tens slot seg=1001111; units slot seg=1111001.
- Load 0x81 in the middle of a UNITS slot:
  - the slot length is unchanged (4 cycles total);
  - the remaining units cycles show 1 = 0110000;
  - the next tens slot shows 8 = 1111111.
- Assert rst together with load=1 mid-TENS -> next edge: an=00, seg=0, err=0, state BLANK; load is ignored.
